// File: rtl/tla_cap_sequencer.sv
// tla_cap_sequencer: per-phase capture config/trigger, ready wait and merged-word drain into a registered valid/ready stage.
// Optional ready timeout with sticky sts_err when TLA_SEQ_TIMEOUT_EN is defined.
module tla_cap_sequencer #(
  parameter int TOP0_0 = 3,
  parameter int LDD0_0 = 32,
  parameter int ADC0_1 = 56,
  parameter int ADC0_2 = 2,
  parameter int LEN_W = 16
`ifdef TLA_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_W = 24
`endif
) (
  input  logic              Gc_clk125,
  input  logic              Gc_rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_mode,
  input  logic [TOP0_0-1:0] cfg_wdis,
  input  logic [LDD0_0-1:0] cfg_plus,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADC0_2-1:0] cfg_nphase,
  output logic              Gc_cap_mode,
  output logic [TOP0_0-1:0] Gc_cap_wdis,
  output logic [LDD0_0-1:0] Gc_cap_plus,
  output logic              Gc_cap_trig,
  input  logic              Gc_capr_rdy,
  output logic              Gc_cap_cmpt,
  output logic [ADC0_2-1:0] Gc_cap_phase,
  input  logic [ADC0_1-1:0] Gc_merge_data,
  input  logic              Gc_merge_datv,
  output logic              Gc_merge_datr,
  output logic [ADC0_1-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_err,
  output logic [LEN_W-1:0]  sts_wcnt
);
  typedef enum logic [2:0] {IDLE, ARM, TRIG, WAIT_RDY, DRAIN, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic arm_q;
  logic [LEN_W-1:0] len_q, wcnt;
  logic [ADC0_2-1:0] nphase_q;
  logic accept, abort_act, start_act, tmo_hit;
  assign sts_busy = state != IDLE;
  assign abort_act = cfg_abort && sts_busy;
  assign start_act = state == IDLE && cfg_start && !cfg_abort;
  assign Gc_cap_trig = state == TRIG && !cfg_abort;
  assign Gc_cap_cmpt = state == DONE && !cfg_abort;
  assign sts_done = Gc_cap_cmpt;
  assign sts_wcnt = wcnt;
  assign Gc_merge_datr = state == DRAIN && !cfg_abort && wcnt < len_q && (!out_valid || out_ready);
  assign accept = Gc_merge_datr && Gc_merge_datv;
`ifdef TLA_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic err_q;
  assign sts_err = err_q;
  // Leave on the edge where the counter would reach all-ones.
  assign tmo_hit = state == WAIT_RDY && !Gc_capr_rdy && tmo_cnt == {{(TMO_W-1){1'b1}}, 1'b0};
  always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
    if (!Gc_rst) begin
      tmo_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_cnt <= state == WAIT_RDY ? tmo_cnt + 1'b1 : '0;
      if (start_act) err_q <= 1'b0;
      else if (tmo_hit && !cfg_abort) err_q <= 1'b1;
    end
  end
`else
  assign sts_err = 1'b0;
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    if (abort_act) state_nx = IDLE;
    else
      case (state)
        IDLE:     state_nx = start_act ? ARM : IDLE;
        ARM:      state_nx = arm_q ? TRIG : ARM;
        TRIG:     state_nx = WAIT_RDY;
        WAIT_RDY: state_nx = Gc_capr_rdy ? (len_q == '0 ? NEXT : DRAIN) : (tmo_hit ? IDLE : WAIT_RDY);
        DRAIN:    state_nx = (wcnt == len_q && !out_valid) ? NEXT : DRAIN;
        NEXT:     state_nx = Gc_cap_phase == nphase_q ? DONE : ARM;
        DONE:     state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
  end
  always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
    if (!Gc_rst) begin
      state <= IDLE;
      arm_q <= 1'b0;
      Gc_cap_mode <= 1'b0;
      Gc_cap_wdis <= '0;
      Gc_cap_plus <= '0;
      Gc_cap_phase <= '0;
      len_q <= '0;
      nphase_q <= '0;
      wcnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      arm_q <= state == ARM && !arm_q && state_nx == ARM;
      if (start_act) begin
        Gc_cap_mode <= cfg_mode;
        Gc_cap_wdis <= cfg_wdis;
        Gc_cap_plus <= cfg_plus;
        len_q <= cfg_len;
        nphase_q <= cfg_nphase;
        Gc_cap_phase <= '0;
      end else if (state == NEXT && !cfg_abort && Gc_cap_phase != nphase_q)
        Gc_cap_phase <= Gc_cap_phase + 1'b1;
      if (state == ARM) wcnt <= '0;
      else if (accept) wcnt <= wcnt + 1'b1;
      if (abort_act) out_valid <= 1'b0;
      else if (accept) begin
        out_data <= Gc_merge_data;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tla_cap_sequencer.sv
// tb_tla_cap_sequencer: directed scenario tasks for tla_cap_sequencer with inline checks.
module tb_tla_cap_sequencer;
  localparam int TOP0_0 = 3, LDD0_0 = 32, ADC0_1 = 56, ADC0_2 = 2, LEN_W = 16;
  localparam logic [ADC0_1-1:0] BASE = 56'hA5_0000_0000_0000;
  logic Gc_clk125 = 0, Gc_rst = 0;
  logic cfg_start = 0, cfg_abort = 0, cfg_mode = 0;
  logic [TOP0_0-1:0] cfg_wdis = '0;
  logic [LDD0_0-1:0] cfg_plus = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [ADC0_2-1:0] cfg_nphase = '0;
  logic Gc_cap_mode, Gc_cap_trig, Gc_cap_cmpt, Gc_merge_datr, out_valid;
  logic [TOP0_0-1:0] Gc_cap_wdis;
  logic [LDD0_0-1:0] Gc_cap_plus;
  logic [ADC0_2-1:0] Gc_cap_phase;
  logic Gc_capr_rdy = 0, Gc_merge_datv = 1, out_ready = 1;
  logic [ADC0_1-1:0] Gc_merge_data, out_data;
  logic sts_busy, sts_done, sts_err;
  logic [LEN_W-1:0] sts_wcnt;
  int compared = 0, mismatched = 0;
  int n_trig = 0, n_cmpt = 0, n_done = 0, n_datr = 0, src_idx = 0;
  logic [ADC0_1-1:0] got[$];
  logic [ADC0_2-1:0] trig_ph[$];

  assign Gc_merge_data = BASE + ADC0_1'(src_idx);
  always #5 Gc_clk125 = ~Gc_clk125;

  tla_cap_sequencer #(
    .TOP0_0(TOP0_0), .LDD0_0(LDD0_0), .ADC0_1(ADC0_1), .ADC0_2(ADC0_2), .LEN_W(LEN_W)
`ifdef TLA_SEQ_TIMEOUT_EN
    , .TMO_W(4)
`endif
  ) dut (
    .Gc_clk125(Gc_clk125), .Gc_rst(Gc_rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_wdis(cfg_wdis), .cfg_plus(cfg_plus), .cfg_len(cfg_len),
    .cfg_nphase(cfg_nphase), .Gc_cap_mode(Gc_cap_mode), .Gc_cap_wdis(Gc_cap_wdis),
    .Gc_cap_plus(Gc_cap_plus), .Gc_cap_trig(Gc_cap_trig), .Gc_capr_rdy(Gc_capr_rdy),
    .Gc_cap_cmpt(Gc_cap_cmpt), .Gc_cap_phase(Gc_cap_phase), .Gc_merge_data(Gc_merge_data),
    .Gc_merge_datv(Gc_merge_datv), .Gc_merge_datr(Gc_merge_datr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sts_busy(sts_busy), .sts_done(sts_done),
    .sts_err(sts_err), .sts_wcnt(sts_wcnt)
  );

  always @(posedge Gc_clk125) begin
    if (Gc_cap_trig) begin
      n_trig <= n_trig + 1;
      trig_ph.push_back(Gc_cap_phase);
    end
    if (Gc_cap_cmpt) n_cmpt <= n_cmpt + 1;
    if (sts_done) n_done <= n_done + 1;
    if (Gc_merge_datr) n_datr <= n_datr + 1;
    if (Gc_merge_datv && Gc_merge_datr) src_idx <= src_idx + 1;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Gc_clk125);
  endtask

  task automatic start_acq(input logic [LEN_W-1:0] len, input logic [ADC0_2-1:0] nph);
    cfg_mode = 0; cfg_wdis = 3'd1; cfg_plus = 32'hCAFE; cfg_len = len; cfg_nphase = nph;
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic rdy_after(input int dly);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) if (Gc_cap_trig) ok = 1; else tick();
    compared++;
    if (!ok) begin mismatched++; $display("FAIL trig_wait: trig not seen within 200 cycles, required 1"); end
    tick(dly);
    Gc_capr_rdy = 1;
    tick();
    Gc_capr_rdy = 0;
  endtask

  task automatic wait_cmpt(output bit seen, output bit done_with);
    seen = 0; done_with = 0;
    for (int i = 0; i < 400 && !seen; i++)
      if (Gc_cap_cmpt) begin seen = 1; done_with = sts_done; end
      else tick();
    compared++;
    if (!seen) begin mismatched++; $display("FAIL cmpt_wait: cmpt not seen within 400 cycles, required 1"); end
  endtask

  task automatic test_reset();
    Gc_rst = 0; cfg_mode = 1; cfg_plus = 32'hFFFF;
    tick(2);
    compared++;
    if ({sts_busy, out_valid, Gc_cap_trig, Gc_cap_cmpt, Gc_merge_datr, sts_done, sts_err} !== 7'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b required 0", {sts_busy, out_valid, Gc_cap_trig, Gc_cap_cmpt, Gc_merge_datr, sts_done, sts_err});
    end
    compared++;
    if ({Gc_cap_mode, Gc_cap_wdis, Gc_cap_plus, Gc_cap_phase, sts_wcnt, out_data} !== '0) begin
      mismatched++; $display("FAIL reset_regs: plus=%0h phase=%0d wcnt=%0d required 0", Gc_cap_plus, Gc_cap_phase, sts_wcnt);
    end
    Gc_rst = 1;
    tick();
  endtask

  task automatic test_single();
    int t0 = n_trig, c0 = n_cmpt, d0 = n_done, w0 = got.size(), s0 = src_idx, k = 0;
    bit cfg_ok = 0, seen, dw;
    cfg_mode = 1; cfg_wdis = 3'd5; cfg_plus = 32'h1234; cfg_len = 4; cfg_nphase = 0;
    cfg_start = 1;
    do begin
      tick(); k++; cfg_start = 0;
      if (k == 1) cfg_ok = Gc_cap_mode === 1'b1 && Gc_cap_wdis === 3'd5 && Gc_cap_plus === 32'h1234;
    end while (!Gc_cap_trig && k < 20);
    compared++;
    if (k !== 3) begin mismatched++; $display("FAIL single_trig_latency: got %0d required 3", k); end
    compared++;
    if (!cfg_ok) begin mismatched++; $display("FAIL single_cfg_first_arm: got 0 required 1"); end
    cfg_wdis = 3'd2; cfg_start = 1;
    tick();
    cfg_start = 0;
    tick(9);
    Gc_capr_rdy = 1;
    tick();
    Gc_capr_rdy = 0;
    wait_cmpt(seen, dw);
    compared++;
    if (dw !== 1'b1) begin mismatched++; $display("FAIL single_done_with_cmpt: got %b required 1", dw); end
    tick();
    compared++;
    if (Gc_cap_wdis !== 3'd5) begin mismatched++; $display("FAIL single_busy_start_ignored: wdis got %0d required 5", Gc_cap_wdis); end
    compared++;
    if (sts_busy !== 1'b0) begin mismatched++; $display("FAIL single_idle: busy got %b required 0", sts_busy); end
    compared++;
    if (got.size() - w0 !== 4) begin mismatched++; $display("FAIL single_words: got %0d required 4", got.size() - w0); end
    for (int i = 0; i < 4 && w0 + i < got.size(); i++) begin
      compared++;
      if (got[w0+i] !== BASE + ADC0_1'(s0 + i)) begin
        mismatched++; $display("FAIL single_word%0d: got %h required %h", i, got[w0+i], BASE + ADC0_1'(s0 + i));
      end
    end
    compared++;
    if ({n_trig - t0, n_cmpt - c0, n_done - d0} !== {32'd1, 32'd1, 32'd1}) begin
      mismatched++; $display("FAIL single_pulses: trig=%0d cmpt=%0d done=%0d required 1/1/1", n_trig - t0, n_cmpt - c0, n_done - d0);
    end
    compared++;
    if (Gc_cap_phase !== 2'd0) begin mismatched++; $display("FAIL single_phase: got %0d required 0", Gc_cap_phase); end
  endtask

  task automatic test_multi_phase();
    int t0 = n_trig, c0 = n_cmpt, w0 = got.size(), s0 = src_idx, p0 = trig_ph.size();
    bit seen, dw;
    start_acq(2, 3);
    for (int p = 0; p < 4; p++) rdy_after(2);
    wait_cmpt(seen, dw);
    tick();
    compared++;
    if (n_trig - t0 !== 4 || n_cmpt - c0 !== 1) begin
      mismatched++; $display("FAIL multi_pulses: trig=%0d cmpt=%0d required 4/1", n_trig - t0, n_cmpt - c0);
    end
    for (int p = 0; p < 4 && p0 + p < trig_ph.size(); p++) begin
      compared++;
      if (trig_ph[p0+p] !== 2'(p)) begin mismatched++; $display("FAIL multi_phase%0d: got %0d required %0d", p, trig_ph[p0+p], p); end
    end
    compared++;
    if (got.size() - w0 !== 8) begin mismatched++; $display("FAIL multi_words: got %0d required 8", got.size() - w0); end
    for (int i = 0; i < 8 && w0 + i < got.size(); i++) begin
      compared++;
      if (got[w0+i] !== BASE + ADC0_1'(s0 + i)) begin
        mismatched++; $display("FAIL multi_word%0d: got %h required %h", i, got[w0+i], BASE + ADC0_1'(s0 + i));
      end
    end
    compared++;
    if (Gc_cap_phase !== 2'd3) begin mismatched++; $display("FAIL multi_final_phase: got %0d required 3", Gc_cap_phase); end
  endtask

  task automatic test_backpressure();
    int w0 = got.size(), s0 = src_idx, viol = 0;
    bit seen = 0;
    start_acq(8, 0);
    rdy_after(3);
    for (int i = 0; i < 200 && !seen; i++) begin
      out_ready = ~out_ready;
      #1;
      if (Gc_merge_datr && out_valid && !out_ready) viol++;
      if (Gc_cap_cmpt) seen = 1;
      tick();
    end
    out_ready = 1;
    compared++;
    if (!seen) begin mismatched++; $display("FAIL bp_cmpt: not seen, required 1"); end
    compared++;
    if (viol !== 0) begin mismatched++; $display("FAIL bp_datr_stall: got %0d violations required 0", viol); end
    compared++;
    if (got.size() - w0 !== 8) begin mismatched++; $display("FAIL bp_words: got %0d required 8", got.size() - w0); end
    for (int i = 0; i < 8 && w0 + i < got.size(); i++) begin
      compared++;
      if (got[w0+i] !== BASE + ADC0_1'(s0 + i)) begin
        mismatched++; $display("FAIL bp_word%0d: got %h required %h", i, got[w0+i], BASE + ADC0_1'(s0 + i));
      end
    end
    compared++;
    if (sts_wcnt !== 16'd8) begin mismatched++; $display("FAIL bp_wcnt: got %0d required 8", sts_wcnt); end
  endtask

  task automatic test_zero_len();
    int t0 = n_trig, c0 = n_cmpt, w0 = got.size(), r0 = n_datr;
    bit seen, dw;
    start_acq(0, 1);
    rdy_after(2);
    rdy_after(2);
    wait_cmpt(seen, dw);
    tick();
    compared++;
    if (n_trig - t0 !== 2 || n_cmpt - c0 !== 1) begin
      mismatched++; $display("FAIL zero_pulses: trig=%0d cmpt=%0d required 2/1", n_trig - t0, n_cmpt - c0);
    end
    compared++;
    if (n_datr - r0 !== 0 || got.size() - w0 !== 0) begin
      mismatched++; $display("FAIL zero_no_data: datr=%0d words=%0d required 0/0", n_datr - r0, got.size() - w0);
    end
  endtask

  task automatic test_abort();
    int c0 = n_cmpt, d0 = n_done, w0 = got.size(), s0 = src_idx, p0, s1, w1;
    bit seen, dw;
    start_acq(6, 0);
    rdy_after(2);
    for (int i = 0; i < 100 && got.size() - w0 < 3; i++) tick();
    cfg_abort = 1;
    tick();
    cfg_abort = 0;
    compared++;
    if ({sts_busy, out_valid, Gc_merge_datr} !== 3'b000) begin
      mismatched++; $display("FAIL abort_clear: busy/valid/datr got %b required 000", {sts_busy, out_valid, Gc_merge_datr});
    end
    tick(5);
    compared++;
    if (n_cmpt - c0 !== 0 || n_done - d0 !== 0) begin
      mismatched++; $display("FAIL abort_no_cmpt: cmpt=%0d done=%0d required 0/0", n_cmpt - c0, n_done - d0);
    end
    for (int i = 0; i < 3 && w0 + i < got.size(); i++) begin
      compared++;
      if (got[w0+i] !== BASE + ADC0_1'(s0 + i)) begin
        mismatched++; $display("FAIL abort_word%0d: got %h required %h", i, got[w0+i], BASE + ADC0_1'(s0 + i));
      end
    end
    p0 = trig_ph.size(); s1 = src_idx; w1 = got.size(); c0 = n_cmpt;
    start_acq(2, 0);
    compared++;
    if (Gc_cap_phase !== 2'd0) begin mismatched++; $display("FAIL restart_phase: got %0d required 0", Gc_cap_phase); end
    rdy_after(2);
    wait_cmpt(seen, dw);
    tick();
    compared++;
    if (got.size() - w1 !== 2 || n_cmpt - c0 !== 1 || trig_ph.size() - p0 !== 1) begin
      mismatched++; $display("FAIL restart_run: words=%0d cmpt=%0d trigs=%0d required 2/1/1", got.size() - w1, n_cmpt - c0, trig_ph.size() - p0);
    end
    for (int i = 0; i < 2 && w1 + i < got.size(); i++) begin
      compared++;
      if (got[w1+i] !== BASE + ADC0_1'(s1 + i)) begin
        mismatched++; $display("FAIL restart_word%0d: got %h required %h", i, got[w1+i], BASE + ADC0_1'(s1 + i));
      end
    end
  endtask

  task automatic test_timeout();
    int c0 = n_cmpt;
    bit ok = 0;
`ifdef TLA_SEQ_TIMEOUT_EN
    bit b15 = 0, b16 = 1, e16 = 0;
    start_acq(1, 0);
    for (int i = 0; i < 50 && !ok; i++) if (Gc_cap_trig) ok = 1; else tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) b15 = sts_busy;
      if (k == 16) begin b16 = sts_busy; e16 = sts_err; end
    end
    compared++;
    if ({b15, b16, e16} !== 3'b101) begin
      mismatched++; $display("FAIL tmo_exit: busy15/busy16/err got %b required 101", {b15, b16, e16});
    end
    compared++;
    if (n_cmpt - c0 !== 0) begin mismatched++; $display("FAIL tmo_no_cmpt: got %0d required 0", n_cmpt - c0); end
    start_acq(1, 0);
    compared++;
    if (sts_err !== 1'b0) begin mismatched++; $display("FAIL tmo_err_clear: got %b required 0", sts_err); end
    cfg_abort = 1;
    tick();
    cfg_abort = 0;
`else
    start_acq(1, 0);
    for (int i = 0; i < 50 && !ok; i++) if (Gc_cap_trig) ok = 1; else tick();
    tick(40);
    compared++;
    if ({sts_busy, sts_err} !== 2'b10) begin
      mismatched++; $display("FAIL wait_forever: busy/err got %b required 10", {sts_busy, sts_err});
    end
    cfg_abort = 1;
    tick();
    cfg_abort = 0;
    compared++;
    if (sts_busy !== 1'b0 || n_cmpt - c0 !== 0) begin
      mismatched++; $display("FAIL wait_abort: busy=%b cmpt=%0d required 0/0", sts_busy, n_cmpt - c0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_single();
    test_multi_phase();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_timeout();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tla_cap_sequencer.md
Name: tla_cap_sequencer

Overview:
Capture sequencer in the Gc_clk125 domain, ahead of the logic-analyser L2A bridge. Host software starts one acquisition. The block then:
- drives the capture configuration (mode, window, plus) and issues the capture trigger;
- waits for the capture-ready return;
- drains a fixed number of merged words per phase;
- steps the capture phase and signals completion.
Captured words are forwarded to a downstream sink through a registered valid/ready stage.

Parameters:
TOP0_0, 3, capture window select width
LDD0_0, 32, capture plus/delay word width
ADC0_1, 56, merged data word width
ADC0_2, 2, capture phase width
LEN_W, 16, words-per-phase counter width
TMO_W, 24, ready-timeout counter width (used only with the optional feature)

Ports:
Gc_clk125 in 1 system clock
Gc_rst in 1 asynchronous active-low reset
cfg_start in 1 single-cycle acquisition start
cfg_abort in 1 single-cycle abort
cfg_mode in 1 capture mode
cfg_wdis in TOP0_0 capture window
cfg_plus in LDD0_0 capture plus value
cfg_len in LEN_W words per phase
cfg_nphase in ADC0_2 last phase index (number of phases minus 1)
Gc_cap_mode out 1 latched mode
Gc_cap_wdis out TOP0_0 latched window
Gc_cap_plus out LDD0_0 latched plus
Gc_cap_trig out 1 trigger pulse
Gc_capr_rdy in 1 capture ready
Gc_cap_cmpt out 1 acquisition complete pulse
Gc_cap_phase out ADC0_2 current phase
Gc_merge_data in ADC0_1 merged word
Gc_merge_datv in 1 merged word valid
Gc_merge_datr out 1 merged word ready
out_data out ADC0_1 forwarded word
out_valid out 1 forwarded word valid
out_ready in 1 sink ready
sts_busy out 1 sequencer not idle
sts_done out 1 done pulse
sts_err out 1 sticky timeout error
sts_wcnt out LEN_W words accepted in current phase

Behaviour:
- Reset (Gc_rst=0, asynchronous): all outputs 0, state IDLE, phase 0, wcnt 0.
- States: IDLE, ARM, TRIG, WAIT_RDY, DRAIN, NEXT, DONE.
- IDLE:
  - cfg_start=1 latches all cfg_* inputs, clears sts_err and sets phase=0, then goes to ARM.
  - cfg_start while not IDLE is ignored.
- ARM:
  - Lasts 2 cycles; the Gc_cap_mode/wdis/plus outputs are stable from the first ARM cycle as settle time for the crossing.
  - Clears wcnt, then goes to TRIG.
- TRIG: Gc_cap_trig=1 for exactly this one cycle, then WAIT_RDY.
- WAIT_RDY: Gc_capr_rdy sampled 1 goes to DRAIN (or to NEXT when latched len=0).
- DRAIN:
  - Gc_merge_datr = (wcnt<len) && (!out_valid || out_ready).
  - A transfer occurs when datv&&datr. The word is registered into out_data, out_valid=1 on the next cycle, and wcnt increments.
  - out_valid is held until out_ready. Simultaneous out_ready and a new accept reloads the register with no bubble.
  - Exit to NEXT when wcnt==len and out_valid==0.
- NEXT:
  - If phase==cfg_nphase, go to DONE.
  - Otherwise phase increments and the state returns to ARM.
  - Gc_cap_phase changes only here.
- DONE: Gc_cap_cmpt=1 and sts_done=1 for one cycle, then IDLE. Config outputs hold their last values.
- Abort:
  - cfg_abort in any non-IDLE state goes to IDLE next cycle.
  - out_valid, datr and trig are cleared and the pending word is dropped.
  - No cmpt/done pulse, sts_err unchanged.
  - Abort wins over a simultaneous start.
- Other rules:
  - sts_busy = (state!=IDLE).
  - wcnt saturates at len and never wraps.
  - Phase wraps are impossible because nphase is at most 2^ADC0_2-1.

Optional Feature:
TLA_SEQ_TIMEOUT_EN:
- Defined: WAIT_RDY runs a TMO_W-bit counter, cleared on entry. On reaching 2^TMO_W-1 without capr_rdy, the block sets sts_err=1 (sticky until the next start) and goes to IDLE with no cmpt.
- Not defined: WAIT_RDY waits indefinitely (abort is the only exit), and sts_err is tied 0.

Test Plan:
- Single phase: start with len=4, nphase=0, mode=1, wdis=5, plus=0x1234; capr_rdy after 10 cycles; feed 4 words with out_ready=1 -> trig pulses once 3 cycles after start, 4 words out in order, cmpt/done pulse once, phase stays 0.
- Multi-phase: len=2, nphase=3 -> 4 trig pulses, phase steps 0,1,2,3, 8 words forwarded, one cmpt at the end.
- Backpressure: len=8, out_ready toggling 1/0 every cycle, datv held 1 -> no word lost or duplicated, datr low whenever out_valid&&!out_ready, wcnt ends at 8.
- Zero length: len=0, nphase=1 -> 2 trigs, no datr assertion, cmpt after the second capr_rdy.
- Abort mid-drain: abort after the 3rd of 6 words -> next cycle busy=0 and out_valid=0, no cmpt; a subsequent start runs normally from phase 0.
- Timeout (macro on, TMO_W=4): capr_rdy held 0 -> sts_err=1 and return to IDLE 15 cycles after entering WAIT_RDY; the next start clears sts_err.
